// File: rtl/if_inst_queue_pkg.sv
// ----------------------------------------------------------------------------
// if_inst_queue_pkg
// Shared pipeline definitions for the IF-to-ID instruction queue.
//   iq_entry_t        : one buffered beat {pc, inst, adef}
//   IQ_DEPTH_DEFAULT  : default queue depth
//   RESET_PC          : architectural reset PC of the core
//   pcMisaligned()    : instruction-address-fault test on a fetch PC
// ----------------------------------------------------------------------------
package if_inst_queue_pkg;

    localparam int          IQ_DEPTH_DEFAULT = 4;
    localparam logic [31:0] RESET_PC         = 32'h1c00_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adef;
    } iq_entry_t;

    localparam int IQ_ENTRY_W = $bits(iq_entry_t);

    // Instructions are word aligned; any low PC bit set is an address fault.
    function automatic logic pcMisaligned(input logic [31:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/if_inst_queue_sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo_reg
// Generic register-based circular FIFO.
// Ports:
//   clk      : clock, rising edge
//   resetn   : asynchronous active-low reset (pointers and count only)
//   i_clear  : synchronous clear, wins over push and pop
//   i_push   : write i_wdata at tail (ignored when full)
//   i_pop    : retire head entry (ignored when empty)
//   i_wdata  : write data
//   o_rdata  : head entry, read combinationally
//   o_count  : occupancy, 0..DEPTH
//   o_full   : occupancy equals DEPTH
//   o_empty  : occupancy equals 0
// ----------------------------------------------------------------------------
module sync_fifo_reg #(
    parameter  int WIDTH = 65,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_doPush;
    logic w_doPop;

    assign w_full   = (r_count == CNT_W'(DEPTH));
    assign w_empty  = (r_count == '0);
    // A full FIFO does not accept a write even if it is popped in the same
    // cycle, so the push qualifier looks only at the registered count.
    assign w_doPush = i_push && !w_full  && !i_clear;
    assign w_doPop  = i_pop  && !w_empty && !i_clear;

    // Pointer and occupancy state. DEPTH is a power of two so the pointers
    // wrap on their own; the count is one bit wider to represent "full".
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_doPop) begin
                r_head <= r_head + PTR_W'(1);
            end
            if (w_doPush && !w_doPop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_doPop && !w_doPush) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Entry storage carries no reset; stale data is masked by the count.
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_tail] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[r_head];
    assign o_count = r_count;
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

// File: rtl/if_inst_queue.sv
// ----------------------------------------------------------------------------
// if_inst_queue
// Decode-side instruction queue between the fetch stage and ID.
// Ports:
//   clk, resetn  : clock / asynchronous active-low reset
//   fs2ds_valid  : fetch presents a beat {inst, fs_pc}
//   inst, fs_pc  : fetched instruction and its PC
//   ds_allowin   : queue can take a beat this cycle
//   flush        : redirect, drops all contents and the incoming beat
//   iq_valid     : head entry valid
//   iq_inst      : head instruction
//   iq_pc        : head PC
//   iq_adef      : head PC misaligned
//   id_ready     : decode consumes the head this cycle
//   iq_count     : current occupancy
// ----------------------------------------------------------------------------
module if_inst_queue
    import if_inst_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     fs2ds_valid,
    input  logic [31:0]              inst,
    input  logic [31:0]              fs_pc,
    output logic                     ds_allowin,
    input  logic                     flush,
    output logic                     iq_valid,
    output logic [31:0]              iq_inst,
    output logic [31:0]              iq_pc,
    output logic                     iq_adef,
    input  logic                     id_ready,
    output logic [$clog2(DEPTH):0]   iq_count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    iq_entry_t        w_wrEntry;
    iq_entry_t        w_rdEntry;
    logic [CNT_W-1:0] w_count;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    assign w_wrEntry.pc   = fs_pc;
    assign w_wrEntry.inst = inst;
    assign w_wrEntry.adef = pcMisaligned(fs_pc);

    // ds_allowin is formed from registered state and flush only, keeping the
    // fetch-side ready free of any path from fetch or decode handshakes.
    assign ds_allowin = !w_full || flush;
    assign w_push     = fs2ds_valid && ds_allowin && !flush;
    assign w_pop      = !w_empty && id_ready && !flush;

    sync_fifo_reg #(
        .WIDTH (IQ_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_clear (flush),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_wrEntry),
        .o_rdata (w_rdEntry),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign iq_valid = !w_empty;
    assign iq_inst  = w_rdEntry.inst;
    assign iq_pc    = w_rdEntry.pc;
    assign iq_adef  = w_rdEntry.adef;
    assign iq_count = w_count;

endmodule

// File: tb/tb_if_inst_queue.sv
// ----------------------------------------------------------------------------
// tb_if_inst_queue
// Self-checking bench for if_inst_queue (DEPTH = 4) against a queue-based
// reference model of the FIFO handshake rules.
// ----------------------------------------------------------------------------
module tb_if_inst_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        fs2ds_valid;
    logic [31:0] inst;
    logic [31:0] fs_pc;
    logic        ds_allowin;
    logic        flush;
    logic        iq_valid;
    logic [31:0] iq_inst;
    logic [31:0] iq_pc;
    logic        iq_adef;
    logic        id_ready;
    logic [2:0]  iq_count;

    int total = 0;
    int bad   = 0;

    // Reference model: the queue contents, oldest first.
    logic [31:0] mPc[$];
    logic [31:0] mInst[$];

    always #5 clk = ~clk;

    if_inst_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .fs2ds_valid (fs2ds_valid),
        .inst        (inst),
        .fs_pc       (fs_pc),
        .ds_allowin  (ds_allowin),
        .flush       (flush),
        .iq_valid    (iq_valid),
        .iq_inst     (iq_inst),
        .iq_pc       (iq_pc),
        .iq_adef     (iq_adef),
        .id_ready    (id_ready),
        .iq_count    (iq_count)
    );

    // Occupancy bounds: never above DEPTH (an underflow wraps above it too).
    always @(negedge clk) begin
        if (resetn) begin
            assert (iq_count <= 3'(DEPTH))
                else $error("[TB] FAIL occupancy bound: iq_count=%0d", iq_count);
        end
    end

    // Drives one cycle of inputs, lets one rising edge pass and advances the
    // model by the handshake rules; returns 1 ns after the edge.
    task automatic applyStimulus(input logic v, input logic [31:0] pc,
                                 input logic [31:0] in, input logic rdy,
                                 input logic fl);
        bit doPush;
        bit doPop;
        fs2ds_valid = v;
        fs_pc       = pc;
        inst        = in;
        id_ready    = rdy;
        flush       = fl;
        doPush = v && (mPc.size() < DEPTH) && !fl;
        doPop  = rdy && (mPc.size() > 0) && !fl;
        @(posedge clk);
        #1;
        if (fl) begin
            mPc.delete();
            mInst.delete();
        end else begin
            if (doPop) begin
                void'(mPc.pop_front());
                void'(mInst.pop_front());
            end
            if (doPush) begin
                mPc.push_back(pc);
                mInst.push_back(in);
            end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        total++;
        if (iq_valid !== 1'b0 || iq_count !== 3'd0 || ds_allowin !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_held: valid=%b count=%0d allowin=%b want 0/0/1",
                     iq_valid, iq_count, ds_allowin);
        end
        resetn = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        total++;
        if (iq_valid !== 1'b0 || iq_count !== 3'd0 || ds_allowin !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_idle: valid=%b count=%0d allowin=%b want 0/0/1",
                     iq_valid, iq_count, ds_allowin);
        end
        // Build count 3, then pulse reset in the middle of a cycle.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h1c00_0000 + 32'(4 * i), 32'h11 + 32'(i), 1'b0, 1'b0);
        end
        fs2ds_valid = 1'b0;
        total++;
        if (iq_count !== 3'd3) begin
            bad++;
            $display("[TB] FAIL reset_precount: count=%0d want 3", iq_count);
        end
        #2 resetn = 1'b0;
        #1;
        total++;
        if (iq_valid !== 1'b0 || iq_count !== 3'd0 || ds_allowin !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_async: valid=%b count=%0d allowin=%b want 0/0/1",
                     iq_valid, iq_count, ds_allowin);
        end
        mPc.delete();
        mInst.delete();
        #2 resetn = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_fill();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 32'h1c00_0000 + 32'(4 * k), 32'hA0 + 32'(k), 1'b0, 1'b0);
            total++;
            if (iq_count !== 3'(k + 1)) begin
                bad++;
                $display("[TB] FAIL fill_count: count=%0d want %0d", iq_count, k + 1);
            end
        end
        total++;
        if (ds_allowin !== 1'b0) begin
            bad++;
            $display("[TB] FAIL fill_allowin: allowin=%b want 0", ds_allowin);
        end
        // Fifth beat held by the fetch stage; nothing may be written.
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b1, 32'h1c00_0010, 32'hA4, 1'b0, 1'b0);
            total++;
            if (iq_count !== 3'd4 || iq_inst !== 32'hA0 || iq_pc !== 32'h1c00_0000) begin
                bad++;
                $display("[TB] FAIL fill_hold: count=%0d inst=%h pc=%h want 4/a0/1c000000",
                         iq_count, iq_inst, iq_pc);
            end
        end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (iq_valid !== 1'b1 || iq_inst !== 32'hA0 + 32'(k) ||
                iq_pc !== 32'h1c00_0000 + 32'(4 * k)) begin
                bad++;
                $display("[TB] FAIL drain_order: valid=%b inst=%h pc=%h want 1/%h/%h",
                         iq_valid, iq_inst, iq_pc, 32'hA0 + 32'(k), 32'h1c00_0000 + 32'(4 * k));
            end
            applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        end
        total++;
        if (iq_count !== 3'd0 || iq_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL drain_empty: count=%0d valid=%b want 0/0", iq_count, iq_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] seq[$];
        int popIdx = 0;
        for (int k = 0; k < 7; k++) seq.push_back(32'h2000_0000 + 32'(16 * k));
        applyStimulus(1'b1, seq[0], 32'hB0, 1'b0, 1'b0);
        applyStimulus(1'b1, seq[1], 32'hB1, 1'b0, 1'b0);
        for (int k = 2; k < 7; k++) begin
            total++;
            if (iq_pc !== seq[popIdx]) begin
                bad++;
                $display("[TB] FAIL b2b_order: pc=%h want %h", iq_pc, seq[popIdx]);
            end
            applyStimulus(1'b1, seq[k], 32'hB0 + 32'(k), 1'b1, 1'b0);
            popIdx++;
            total++;
            if (iq_count !== 3'd2) begin
                bad++;
                $display("[TB] FAIL b2b_count: count=%0d want 2", iq_count);
            end
        end
        for (int k = 0; k < 2; k++) begin
            total++;
            if (iq_pc !== seq[popIdx]) begin
                bad++;
                $display("[TB] FAIL b2b_tail: pc=%h want %h", iq_pc, seq[popIdx]);
            end
            applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            popIdx++;
        end
    endtask

    task automatic test_wrap();
        int pushed = 0;
        int popped = 0;
        int c = 0;
        bit v;
        bit rdy;
        while (c < 300 && !(pushed == 10 && popped == 10)) begin
            v   = (pushed < 10) && ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            if (rdy && mPc.size() > 0) begin
                total++;
                if (iq_pc !== 32'h1c00_0100 + 32'(4 * popped)) begin
                    bad++;
                    $display("[TB] FAIL wrap_order: pc=%h want %h",
                             iq_pc, 32'h1c00_0100 + 32'(4 * popped));
                end
                popped++;
            end
            if (v && mPc.size() < DEPTH) begin
                applyStimulus(1'b1, 32'h1c00_0100 + 32'(4 * pushed), 32'hC0 + 32'(pushed), rdy, 1'b0);
                pushed++;
            end else begin
                applyStimulus(1'b0, 32'h0, 32'h0, rdy, 1'b0);
            end
            c++;
        end
        total++;
        if (popped != 10 || iq_count !== 3'd0) begin
            bad++;
            $display("[TB] FAIL wrap_done: popped=%0d count=%0d want 10/0", popped, iq_count);
        end
    endtask

    task automatic test_flush();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 32'h1c00_0020 + 32'(4 * k), 32'hD0 + 32'(k), 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 32'h1c00_0030, 32'hD3, 1'b1, 1'b1);
        total++;
        if (iq_count !== 3'd0 || iq_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL flush_clear: count=%0d valid=%b want 0/0", iq_count, iq_valid);
        end
        applyStimulus(1'b1, 32'h1c00_0040, 32'hD4, 1'b0, 1'b0);
        total++;
        if (iq_count !== 3'd1 || iq_pc !== 32'h1c00_0040 || iq_inst !== 32'hD4) begin
            bad++;
            $display("[TB] FAIL flush_refill: count=%0d pc=%h inst=%h want 1/1c000040/d4",
                     iq_count, iq_pc, iq_inst);
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_adef();
        applyStimulus(1'b1, 32'h1c00_0002, 32'hE0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h1c00_0004, 32'hE1, 1'b0, 1'b0);
        total++;
        if (iq_adef !== 1'b1 || iq_pc !== 32'h1c00_0002) begin
            bad++;
            $display("[TB] FAIL adef_set: adef=%b pc=%h want 1/1c000002", iq_adef, iq_pc);
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        total++;
        if (iq_adef !== 1'b0 || iq_pc !== 32'h1c00_0004) begin
            bad++;
            $display("[TB] FAIL adef_clear: adef=%b pc=%h want 0/1c000004", iq_adef, iq_pc);
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] pc;
        logic        expAdef;
        for (int c = 0; c < 300; c++) begin
            pc = $urandom();
            applyStimulus($urandom_range(0, 3) != 0, pc, $urandom(),
                          $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
            total++;
            if (iq_count !== 3'(mPc.size()) || iq_valid !== (mPc.size() != 0) ||
                ds_allowin !== (mPc.size() < DEPTH)) begin
                bad++;
                $display("[TB] FAIL rand_state: count=%0d valid=%b allowin=%b want count %0d",
                         iq_count, iq_valid, ds_allowin, mPc.size());
            end
            if (mPc.size() != 0) begin
                expAdef = (mPc[0] % 4) != 0;
                total++;
                if (iq_pc !== mPc[0] || iq_inst !== mInst[0] || iq_adef !== expAdef) begin
                    bad++;
                    $display("[TB] FAIL rand_head: pc=%h inst=%h adef=%b want %h/%h/%b",
                             iq_pc, iq_inst, iq_adef, mPc[0], mInst[0], expAdef);
                end
            end
        end
    endtask

    initial begin
        resetn      = 1'b0;
        fs2ds_valid = 1'b0;
        inst        = '0;
        fs_pc       = '0;
        flush       = 1'b0;
        id_ready    = 1'b0;
        test_reset();
        test_fill();
        test_back_to_back();
        test_wrap();
        test_flush();
        test_adef();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_inst_queue.md
# if_inst_queue

Instruction queue on the decode side of the IF-to-ID handshake. It accepts fetched instruction/PC beats from the fetch stage over the `fs2ds_valid` / `ds_allowin` handshake and buffers them in a small circular FIFO. It presents the oldest entry to the decode stage over a valid/ready pair. A flush input discards all buffered and in-flight wrong-path instructions on a redirect. It sits between the fetch stage outputs (`inst`, `fs_pc`, `fs2ds_valid`) and the ID stage.

## Interface
- `DEPTH`, 4: number of entries; power of two, at least 2.
- `clk` in 1: sole clock; all state updates on rising edge.
- `resetn` in 1: reset, asynchronous, active-low.
- `fs2ds_valid` in 1: fetch stage presents a valid beat.
- `inst` in 32: fetched instruction word.
- `fs_pc` in 32: PC of `inst`.
- `ds_allowin` out 1: queue can accept a beat this cycle.
- `flush` in 1: redirect; discard all contents and the incoming beat.
- `iq_valid` out 1: head entry valid.
- `iq_inst` out 32: head instruction.
- `iq_pc` out 32: head PC.
- `iq_adef` out 1: head PC misaligned (`pc[1:0]` not equal to 0).
- `id_ready` in 1: decode consumes the head this cycle.
- `iq_count` out clog2(DEPTH)+1: current occupancy.

## Operation
- Push happens when `fs2ds_valid && ds_allowin && !flush`. The entry written at `tail` is {`fs_pc`, `inst`, `fs_pc[1:0]` not equal to 0}; then `tail` increments.
- Pop happens when `iq_valid && id_ready && !flush`; then `head` increments.
- `ds_allowin = !full || flush`. There is no pass-through when full: a pop in the same cycle does not open a slot.
- `iq_valid = (iq_count != 0)`. `iq_inst`, `iq_pc` and `iq_adef` read combinationally from the head entry register. Their values are don't-care while `iq_valid` is 0.
- Pointers are clog2(DEPTH) bits wide and wrap modulo DEPTH naturally.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
  - neither: unchanged
- `full = (iq_count == DEPTH)`. Count never exceeds DEPTH and never underflows. Assertions in the bench check both.
- `flush` has highest priority. Next state is head = tail = 0 and count = 0. The same-cycle incoming beat is dropped and no pop occurs.
- Entry storage is not cleared on flush or reset; only pointers and count are.

## Timing
- Reset (async assert) clears head, tail and count immediately, without waiting for `clk`. Resulting output values:
  - `iq_valid` = 0
  - `iq_count` = 0
  - `ds_allowin` = 1
  - data outputs don't-care
- Reset deassertion takes effect at the first rising edge it releases.
- Push-to-visible latency is 1 cycle. A beat pushed at edge N appears at the head (if the queue was empty) with `iq_valid` = 1 after edge N. There is no same-cycle bypass.
- Pop takes effect at the edge; the next entry is visible immediately after that edge.
- `ds_allowin` depends only on registered count and `flush`. There is no combinational path from `fs2ds_valid`, `inst` or `id_ready` to `ds_allowin`.
- Sustained throughput is 1 push and 1 pop per cycle while 0 < count < DEPTH.
- A full queue with `id_ready` = 1 pops at edge N. `ds_allowin` rises after edge N and a push can occur in cycle N+1.

## Structure
- Shared pipeline package holds:
  - `iq_entry_t` typedef {pc[31:0], inst[31:0], adef}
  - `IQ_DEPTH_DEFAULT = 4`
  - the reset PC constant 0x1c000000
- One natural sub-module, `sync_fifo_reg`. It is a generic register-based circular FIFO parameterised on width and depth, with async active-low reset and a clear input. `if_inst_queue` wraps it and adds handshake mapping, flush gating and `adef` generation.
- Target size is 150–250 lines in total.

## Test plan
- Reset, then release with no traffic: `iq_valid` = 0, `iq_count` = 0, `ds_allowin` = 1. Assert `resetn` low mid-cycle with count 3: outputs clear before the next edge.
- Fill with `id_ready` = 0:
  - push pc 0x1c000000/04/08/0c with inst 0xA0..0xA3.
  - `iq_count` = 4 and `ds_allowin` = 0. A fifth beat is held: the fetch stage keeps presenting it and nothing is written.
  - Raise `id_ready`: drains 0xA0..0xA3 in order, one per cycle.
- At count 2, push and pop in the same cycle for 5 cycles: count stays 2, output order matches push order.
- Wrap-around: interleave pushes and pops to write 10 entries through DEPTH=4. All 10 PCs emerge in order and count returns to 0.
- Flush:
  - count 3, `fs2ds_valid` = 1 and `id_ready` = 1, assert `flush` for one cycle.
  - Next cycle: count 0 and `iq_valid` = 0. The incoming beat is absent and no pop was registered.
  - A subsequent push of pc 0x1c000040 appears at the head.
- Push pc 0x1c000002: `iq_adef` = 1 when it reaches the head. Push pc 0x1c000004: `iq_adef` = 0.
